// File: rtl/watch_pkg.sv
// Shared watch definitions: scheduler state encodings, packed-time field
// offsets and a helper that builds a packed 52-bit time value.
package watch_pkg;

    localparam int TIME_W   = 52;
    localparam int YEAR_LSB = 40;
    localparam int MON_LSB  = 32;
    localparam int DAY_LSB  = 24;
    localparam int HOUR_LSB = 16;
    localparam int MIN_LSB  = 8;
    localparam int SEC_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RINGING = 3'd2,
        ST_SNOOZE  = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    function automatic logic [TIME_W-1:0] pack_time(
        input logic [11:0] year,
        input logic [7:0]  mon,
        input logic [7:0]  day,
        input logic [7:0]  hour,
        input logic [7:0]  minute,
        input logic [7:0]  second
    );
        logic [TIME_W-1:0] t;
        t = '0;
        t[YEAR_LSB +: 12] = year;
        t[MON_LSB  +: 8]  = mon;
        t[DAY_LSB  +: 8]  = day;
        t[HOUR_LSB +: 8]  = hour;
        t[MIN_LSB  +: 8]  = minute;
        t[SEC_LSB  +: 8]  = second;
        return t;
    endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// Alarm scheduler bus: time/alarm/button inputs and status outputs.
// master drives time, alarm and buttons; slave (scheduler) drives status.
interface alarm_scheduler_if;
    import watch_pkg::*;

    logic [TIME_W-1:0] bin_time;
    logic [TIME_W-1:0] bin_alarm;
    logic              btn_snooze;
    logic              btn_stop;
    logic              ringing;
    logic              buzzer;
    logic              snoozing;
    logic [1:0]        snooze_cnt;
    logic              rst_alarm;
    logic [2:0]        state;

    modport master (
        output bin_time, bin_alarm, btn_snooze, btn_stop,
        input  ringing, buzzer, snoozing, snooze_cnt, rst_alarm, state
    );

    modport slave (
        input  bin_time, bin_alarm, btn_snooze, btn_stop,
        output ringing, buzzer, snoozing, snooze_cnt, rst_alarm, state
    );

endinterface

// File: rtl/btn_edge_1hz.sv
// Button level register plus rising-edge detect on the 1 Hz clock.
// Ports: clk1sec, rst (async active-low), btn level in, rise pulse out.
module btn_edge_1hz (
    input  logic clk1sec,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic lvl_q, lvl_d;
    logic prev_q, prev_d;

    always_comb begin
        lvl_d  = btn;
        prev_d = lvl_q;
    end

    always_ff @(posedge clk1sec or negedge rst) begin
        if (!rst) begin
            lvl_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_d;
            prev_q <= prev_d;
        end
    end

    assign rise = lvl_q & ~prev_q;

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm sequencer: matches packed time against the alarm and runs the
// ring / snooze / clear cycle. Ports: clk1sec, rst (async active-low),
// bus (slave): bin_time, bin_alarm, buttons in; status flags out.
module alarm_scheduler
    import watch_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input logic              clk1sec,
    input logic              rst,
    alarm_scheduler_if.slave bus
);

    localparam int RT_W = $clog2(RING_SEC);
    localparam int ST_W = $clog2(SNOOZE_SEC + 1);

    localparam logic [RT_W-1:0] RT_LAST  = RT_W'(RING_SEC - 1);
    localparam logic [ST_W-1:0] SNZ_LOAD = ST_W'(SNOOZE_SEC);
    localparam logic [ST_W-1:0] SNZ_ONE  = ST_W'(1);
    localparam logic [1:0]      SNZ_MAX  = 2'(MAX_SNOOZE);

    state_t          state_q, state_d;
    logic [RT_W-1:0] ring_t_q, ring_t_d;
    logic [ST_W-1:0] snz_t_q, snz_t_d;
    logic [1:0]      snooze_cnt_q, snooze_cnt_d;
    logic            guard_q, guard_d;
    logic            ringing_q, ringing_d;
    logic            buzzer_q, buzzer_d;
    logic            snoozing_q, snoozing_d;
    logic            rst_alarm_q, rst_alarm_d;

    logic armed;
    logic hit;
    logic snz_rise;
    logic stop_rise;

    assign armed = |bus.bin_alarm;
    assign hit   = (bus.bin_time == bus.bin_alarm);

    btn_edge_1hz u_snz_edge (
        .clk1sec (clk1sec),
        .rst     (rst),
        .btn     (bus.btn_snooze),
        .rise    (snz_rise)
    );

    btn_edge_1hz u_stop_edge (
        .clk1sec (clk1sec),
        .rst     (rst),
        .btn     (bus.btn_stop),
        .rise    (stop_rise)
    );

    always_comb begin
        state_d      = state_q;
        ring_t_d     = '0;
        snz_t_d      = '0;
        snooze_cnt_d = snooze_cnt_q;
        // Guard stays up until the match condition has gone away once,
        // so a still-true match never re-fires after clear or reset.
        guard_d      = guard_q & hit;

        unique case (state_q)
            ST_IDLE: begin
                if (armed)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!armed)
                    state_d = ST_IDLE;
                else if (hit && !guard_q)
                    state_d = ST_RINGING;
            end
            ST_RINGING: begin
                ring_t_d = ring_t_q + RT_W'(1);
                if (!armed) begin
                    state_d = ST_IDLE;
                end else if (stop_rise) begin
                    state_d = ST_CLEAR;
                end else if (snz_rise && snooze_cnt_q < SNZ_MAX) begin
                    state_d      = ST_SNOOZE;
                    snz_t_d      = SNZ_LOAD;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                end else if (ring_t_q == RT_LAST) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_SNOOZE: begin
                snz_t_d = snz_t_q - SNZ_ONE;
                if (!armed)
                    state_d = ST_IDLE;
                else if (stop_rise)
                    state_d = ST_CLEAR;
                else if (snz_t_q == SNZ_ONE)
                    state_d = ST_RINGING;
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counters restart from their entry value on every state entry.
        if (state_d != ST_RINGING || state_q != ST_RINGING)
            ring_t_d = '0;
        if (state_d != ST_SNOOZE)
            snz_t_d = '0;

        // Leaving the event (clear or disarm) forgets snoozes used.
        if (state_d == ST_CLEAR || state_d == ST_IDLE)
            snooze_cnt_d = '0;
        if (state_d == ST_CLEAR)
            guard_d = 1'b1;

        ringing_d   = (state_d == ST_RINGING);
        snoozing_d  = (state_d == ST_SNOOZE);
        rst_alarm_d = (state_d == ST_CLEAR);
        // Buzzer starts high on every ring entry, then toggles.
        if (state_d == ST_RINGING)
            buzzer_d = (state_q == ST_RINGING) ? ~buzzer_q : 1'b1;
        else
            buzzer_d = 1'b0;
    end

    always_ff @(posedge clk1sec or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ring_t_q     <= '0;
            snz_t_q      <= '0;
            snooze_cnt_q <= '0;
            guard_q      <= 1'b1;
            ringing_q    <= 1'b0;
            buzzer_q     <= 1'b0;
            snoozing_q   <= 1'b0;
            rst_alarm_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_t_q     <= ring_t_d;
            snz_t_q      <= snz_t_d;
            snooze_cnt_q <= snooze_cnt_d;
            guard_q      <= guard_d;
            ringing_q    <= ringing_d;
            buzzer_q     <= buzzer_d;
            snoozing_q   <= snoozing_d;
            rst_alarm_q  <= rst_alarm_d;
        end
    end

    assign bus.ringing    = ringing_q;
    assign bus.buzzer     = buzzer_q;
    assign bus.snoozing   = snoozing_q;
    assign bus.snooze_cnt = snooze_cnt_q;
    assign bus.rst_alarm  = rst_alarm_q;
    assign bus.state      = state_q;

endmodule
